// File: rtl/conv_pkg.sv
// Shared types for the 5x5 convolution datapath: kernel size and the
// pixel/window shapes exchanged between window generator and convolution point.
package conv_pkg;

    localparam int K        = 5;
    localparam int LINES    = K - 1;
    localparam int BITWIDTH = 32;

    typedef logic [BITWIDTH-1:0] pixel_t;
    typedef pixel_t [K-1:0][K-1:0] window_t;

endpackage

// File: rtl/conv_line_buffer.sv
// Single-clock line store: one combinational read and one write at the same
// address per cycle, so a write always sees the pre-write contents.
module conv_line_buffer #(
    parameter int DEPTH = 32,
    parameter int WIDTH = 128
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] addr,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    assign rdata = mem[addr];

    // NOTE: storage arrays carry no reset; contents are don't-care until written,
    // and leaving them unreset lets synthesis map them onto RAM.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

endmodule

// File: rtl/conv_window_gen.sv
// Turns a raster pixel stream into every valid 5x5 window (stride 1, no padding)
// using four line buffers and a 5x5 shift-register window.
module conv_window_gen
    import conv_pkg::*;
#(
    parameter int bitwidth = BITWIDTH,
    parameter int MAP_W    = 32,
    parameter int MAP_H    = 32
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic [bitwidth-1:0]                  in_pixel,
    input  logic                                 in_valid,
    output logic                                 in_ready,
    output logic [K-1:0][K-1:0][bitwidth-1:0]    map_block,
    output logic                                 out_valid,
    input  logic                                 out_ready,
    output logic [$clog2(MAP_H)-1:0]             out_row,
    output logic [$clog2(MAP_W)-1:0]             out_col,
    output logic                                 frame_done
);

    localparam int RW = $clog2(MAP_H);
    localparam int CW = $clog2(MAP_W);

    logic [RW-1:0] row;
    logic [CW-1:0] col;
    logic          accept;
    logic          emit;
    logic          last_taken;

    // lb_rd[0] is the most recent line, lb_rd[LINES-1] the oldest.
    logic [LINES-1:0][bitwidth-1:0] lb_rd;
    logic [LINES-1:0][bitwidth-1:0] lb_wr;

    assign in_ready   = !out_valid || out_ready;
    assign accept     = in_valid && in_ready;
    assign emit       = accept && (row >= RW'(K-1)) && (col >= CW'(K-1));
    assign last_taken = out_valid && out_ready &&
                        (out_row == RW'(MAP_H-K)) && (out_col == CW'(MAP_W-K));

    always_comb begin
        lb_wr[0] = in_pixel;
        for (int k = 1; k < LINES; k++) begin
            lb_wr[k] = lb_rd[k-1];
        end
    end

    conv_line_buffer #(
        .DEPTH (MAP_W),
        .WIDTH (LINES*bitwidth)
    ) u_lines (
        .clk   (clk),
        .we    (accept),
        .addr  (col),
        .wdata (lb_wr),
        .rdata (lb_rd)
    );

    // NOTE: every register here uses non-blocking assignment so all of them
    // update from the same pre-edge values, regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row        <= '0;
            col        <= '0;
            map_block  <= '0;
            out_valid  <= 1'b0;
            out_row    <= '0;
            out_col    <= '0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= last_taken;

            if (accept) begin
                for (int i = 0; i < K; i++) begin
                    for (int j = 0; j < K-1; j++) begin
                        map_block[i][j] <= map_block[i][j+1];
                    end
                end
                // Column j=K-1 takes the oldest line at the top, the live pixel at the bottom.
                for (int i = 0; i < K-1; i++) begin
                    map_block[i][K-1] <= lb_rd[K-2-i];
                end
                map_block[K-1][K-1] <= in_pixel;

                if (col == CW'(MAP_W-1)) begin
                    col <= '0;
                    row <= (row == RW'(MAP_H-1)) ? '0 : row + 1'b1;
                end else begin
                    col <= col + 1'b1;
                end
            end

            if (emit) begin
                out_valid <= 1'b1;
                out_row   <= row - RW'(K-1);
                out_col   <= col - CW'(K-1);
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_conv_window_gen.sv
// Scoreboard bench for conv_window_gen on an 8x8 map: the driver queues each
// expected window as its last pixel is accepted; a monitor pops and compares.
module tb_conv_window_gen;
    import conv_pkg::*;

    localparam int MW = 8;
    localparam int MH = 8;
    localparam int BW = 32;

    logic                          clk = 1'b0;
    logic                          rst_n = 1'b0;
    logic [BW-1:0]                 in_pixel = '0;
    logic                          in_valid = 1'b0;
    logic                          in_ready;
    logic [K-1:0][K-1:0][BW-1:0]   map_block;
    logic                          out_valid;
    logic                          out_ready = 1'b1;
    logic [2:0]                    out_row;
    logic [2:0]                    out_col;
    logic                          frame_done;

    typedef struct {
        int off;
        int row;
        int col;
        bit last;
    } exp_t;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;
    int   windows_seen = 0;
    int   cyc = 0;
    bit   ready_toggle = 1'b0;
    bit   gap_mode = 1'b0;
    bit   last_emit = 1'b0;

    conv_window_gen #(
        .bitwidth (BW),
        .MAP_W    (MW),
        .MAP_H    (MH)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_pixel   (in_pixel),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .map_block  (map_block),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_row    (out_row),
        .out_col    (out_col),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    // One pixel offer; retried each cycle until accepted or the budget runs out.
    task automatic send(input int r, input int c, input int off);
        int guard = 0;
        forever begin
            @(negedge clk);
            cyc++;
            out_ready = ready_toggle ? ((cyc % 4 == 0) || (cyc % 4 == 3)) : 1'b1;
            if (gap_mode && (cyc % 2 == 1)) begin
                in_valid = 1'b0;
                #1;
                last_emit = 1'b0;
            end else begin
                in_valid = 1'b1;
                in_pixel = BW'(off + r*MW + c);
                #1;
                if (in_ready) begin
                    last_emit = (r >= 4) && (c >= 4);
                    if (last_emit) exp_q.push_back('{off, r-4, c-4, (r == MH-1) && (c == MW-1)});
                    break;
                end
                last_emit = 1'b0;
            end
            guard++;
            if (guard > 50) begin
                check("drive_timeout", 64'(guard), 64'd0);
                break;
            end
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            cyc++;
            in_valid  = 1'b0;
            out_ready = 1'b1;
            #1;
            last_emit = 1'b0;
        end
    endtask

    task automatic send_frame(input int off);
        for (int r = 0; r < MH; r++)
            for (int c = 0; c < MW; c++)
                send(r, c, off);
    endtask

    task automatic finish_test(input string name, input int start, input int want);
        idle(10);
        check({name, "_count"}, 64'(windows_seen - start), 64'(want));
        check({name, "_queue_empty"}, 64'(exp_q.size()), 64'd0);
    endtask

    // Monitor: samples 2 time units after the falling edge, after the driver has settled inputs.
    initial begin
        bit   pv = 1'b0, pr = 1'b0, pe = 1'b0, plast = 1'b0;
        logic [K-1:0][K-1:0][BW-1:0] pblock = '0;
        logic [2:0] prow = '0, pcol = '0;
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (!rst_n) begin
                check("rst_out_valid", 64'(out_valid), 64'd0);
                check("rst_frame_done", 64'(frame_done), 64'd0);
                check("rst_out_pos", 64'({out_row, out_col}), 64'd0);
                check("rst_map_block_zero", 64'(map_block == '0), 64'd1);
                pv = 1'b0; pe = 1'b0; plast = 1'b0;
                continue;
            end
            check("out_valid", 64'(out_valid), 64'(pe || (pv && !pr)));
            check("frame_done", 64'(frame_done), 64'(plast));
            check("in_ready", 64'(in_ready), 64'(!out_valid || out_ready));
            if (pv && !pr) begin
                check("stall_block_stable", 64'(map_block == pblock), 64'd1);
                check("stall_pos_stable", 64'({out_row, out_col}), 64'({prow, pcol}));
            end
            plast = 1'b0;
            if (out_valid && out_ready) begin
                windows_seen++;
                if (exp_q.size() == 0) begin
                    check("unexpected_window", 64'd1, 64'd0);
                end else begin
                    int bi = 0, bj = 0;
                    bit found = 1'b0;
                    e = exp_q.pop_front();
                    check("out_row", 64'(out_row), 64'(e.row));
                    check("out_col", 64'(out_col), 64'(e.col));
                    check("no_straddle", 64'(out_col <= 3'd3), 64'd1);
                    for (int i = 0; i < K; i++)
                        for (int j = 0; j < K; j++)
                            if (!found && map_block[i][j] !== BW'(e.off + (e.row+i)*MW + e.col + j)) begin
                                found = 1'b1; bi = i; bj = j;
                            end
                    check($sformatf("win_px[%0d][%0d]", bi, bj), 64'(map_block[bi][bj]),
                          64'(e.off + (e.row+bi)*MW + e.col + bj));
                    plast = e.last;
                end
            end
            pv = out_valid; pr = out_ready; pe = last_emit;
            pblock = map_block; prow = out_row; pcol = out_col;
        end
    end

    initial begin
        int start;
        rst_n = 1'b0;
        idle(3);
        @(negedge clk);
        rst_n = 1'b1;

        start = windows_seen;
        send_frame(0);
        finish_test("frame_basic", start, 16);

        start = windows_seen;
        ready_toggle = 1'b1;
        send_frame(0);
        ready_toggle = 1'b0;
        finish_test("frame_stall", start, 16);

        start = windows_seen;
        send_frame(0);
        send_frame(100);
        finish_test("two_frames", start, 32);

        for (int r = 0; r < 6; r++)
            for (int c = 0; c < MW; c++)
                if (r < 5 || c <= 3) send(r, c, 0);
        idle(2);
        @(negedge clk);
        rst_n    = 1'b0;
        in_valid = 1'b0;
        last_emit = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        start = windows_seen;
        send_frame(0);
        finish_test("after_reset", start, 16);

        start = windows_seen;
        gap_mode = 1'b1;
        send_frame(0);
        gap_mode = 1'b0;
        finish_test("input_gaps", start, 16);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
